bus_arbiter: RTL

Shares the single memory port (13-bit address, 8-bit data) between the CPU and an external program loader/debug port. The CPU side is the controller's `rd`/`wr` strobes and the address/data muxes. The arbiter freezes the CPU only at a cycle where neither strobe is active, by dropping the controller's `ena`. It then performs loader accesses in bounded bursts and returns ownership with a guaranteed minimum CPU window.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/mem_port_mux.sv | 38 +++
 rtl/bus_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU slice: bus defaults, arbiter state encoding,
// controller opcodes and a small width helper.
package cpu_pkg;

    localparam int unsigned AW_DEF = 13;
    localparam int unsigned DW_DEF = 8;

    // Memory-port arbiter states; CPU must stay 0 so reset lands there.
    typedef enum logic [2:0] {
        ST_CPU    = 3'd0,
        ST_FREEZE = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ACK    = 3'd3,
        ST_HOLD   = 3'd4
    } arb_state_t;

    // Controller instruction opcodes.
    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    // Bits needed to index n values, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Owner select for the shared memory port.
// Ports: ld_sel chooses the loader side; ld_strobe_en enables loader strobes
// (only while an access is in progress); wr_l picks write vs read; cpu_* are
// passed straight through when the CPU owns the port; mem_* drive the memory.
module mem_port_mux #(
    parameter int unsigned AW = 13,
    parameter int unsigned DW = 8
) (
    input  logic          ld_sel,
    input  logic          ld_strobe_en,
    input  logic          wr_l,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr
);

    // ld_sel comes from registered state, so the select never glitches.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        if (ld_sel) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_rd    = ld_strobe_en & ~wr_l;
            mem_wr    = ld_strobe_en &  wr_l;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the memory port between the CPU controller and the program loader.
// The CPU is frozen (cpu_ena low) only on a strobe-free cycle; the loader then
// runs bounded bursts of MEM_LAT-cycle accesses, and after each release the CPU
// keeps the port for at least MIN_CPU cycles unless it is halted.
// Ports: clk/rst (async active-low); cpu_rd/cpu_wr/cpu_addr/cpu_wdata/cpu_halt
// from the controller, cpu_ena back to it; ld_req/ld_wr/ld_addr/ld_wdata from
// the loader, ld_ack/ld_rdata/ld_grant back; mem_* to the memory.
module bus_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned AW        = AW_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned MIN_CPU   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_halt,
    output logic          cpu_ena,
    input  logic          ld_req,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_grant,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned BW   = clog2_min1(MAX_BURST + 1);
    localparam int unsigned CW   = clog2_min1(MIN_CPU + 1);
    localparam int unsigned NW   = clog2_min1(MEM_LAT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [CW-1:0] COOL_INIT = CW'(MIN_CPU);
    localparam logic [NW-1:0] CNT_INIT  = NW'(MEM_LAT - 1);

    arb_state_t    state, state_nx;
    logic [CW-1:0] cool, cool_nx;
    logic [BW-1:0] burst, burst_nx;
    logic [NW-1:0] cnt, cnt_nx;
    logic [AW-1:0] addr_l, addr_nx;
    logic [DW-1:0] wdata_l, wdata_nx;
    logic          wr_l, wr_nx;
    logic [DW-1:0] rdata_nx;
    logic          grant_c;

    // Take the port only when the CPU has no strobe active this cycle.
    assign grant_c = (state == ST_CPU) && ld_req && !cpu_rd && !cpu_wr &&
                     ((cool == '0) || cpu_halt);

    assign cpu_ena  = (state == ST_CPU) && !grant_c;
    assign ld_grant = (state != ST_CPU);
    assign ld_ack   = (state == ST_ACK);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_CPU;
            cool     <= '0;
            burst    <= '0;
            cnt      <= '0;
            addr_l   <= '0;
            wdata_l  <= '0;
            wr_l     <= 1'b0;
            ld_rdata <= '0;
        end else begin
            state    <= state_nx;
            cool     <= cool_nx;
            burst    <= burst_nx;
            cnt      <= cnt_nx;
            addr_l   <= addr_nx;
            wdata_l  <= wdata_nx;
            wr_l     <= wr_nx;
            ld_rdata <= rdata_nx;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nx = state;
        cool_nx  = cool;
        burst_nx = burst;
        cnt_nx   = cnt;
        addr_nx  = addr_l;
        wdata_nx = wdata_l;
        wr_nx    = wr_l;
        rdata_nx = ld_rdata;
        case (state)
            ST_CPU: begin
                if (cool != '0) begin
                    cool_nx = cool - CW'(1);
                end
                if (grant_c) begin
                    state_nx = ST_FREEZE;
                    burst_nx = '0;
                end
            end
            ST_FREEZE: begin
                addr_nx  = ld_addr;
                wdata_nx = ld_wdata;
                wr_nx    = ld_wr;
                cnt_nx   = CNT_INIT;
                state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt == '0) begin
                    if (!wr_l) begin
                        rdata_nx = mem_rdata;
                    end
                    if (burst < BURST_MAX) begin
                        burst_nx = burst + BW'(1);
                    end
                    state_nx = ST_ACK;
                end else begin
                    cnt_nx = cnt - NW'(1);
                end
            end
            ST_ACK: begin
                state_nx = ST_HOLD;
            end
            ST_HOLD: begin
                // Follow-on accesses skip FREEZE: the CPU is already stopped.
                if (ld_req && (burst < BURST_MAX)) begin
                    addr_nx  = ld_addr;
                    wdata_nx = ld_wdata;
                    wr_nx    = ld_wr;
                    cnt_nx   = CNT_INIT;
                    state_nx = ST_ACCESS;
                end else begin
                    cool_nx  = COOL_INIT;
                    state_nx = ST_CPU;
                end
            end
            default: begin
                state_nx = ST_CPU;
            end
        endcase
    end

    mem_port_mux #(
        .AW(AW),
        .DW(DW)
    ) u_mux (
        .ld_sel      (state != ST_CPU),
        .ld_strobe_en(state == ST_ACCESS),
        .wr_l        (wr_l),
        .ld_addr     (addr_l),
        .ld_wdata    (wdata_l),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr)
    );

endmodule
